// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock types: entry FSM states, HH:MM digit limits and the time range check.
package alarm_clock_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } entry_state_t;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;
  localparam logic [3:0] MAX_DIGIT      = 4'd9;
  localparam logic [3:0] KEY_DIGIT_MAX  = 4'd9;

  function automatic logic time_is_valid(input logic [3:0] ms_hr,
                                         input logic [3:0] ls_hr,
                                         input logic [3:0] ms_min,
                                         input logic [3:0] ls_min);
    logic hr_ok;
    if (ms_hr < MAX_MS_HR) begin
      hr_ok = (ls_hr <= MAX_DIGIT);
    end else if (ms_hr == MAX_MS_HR) begin
      hr_ok = (ls_hr <= MAX_LS_HR_AT_2);
    end else begin
      hr_ok = 1'b0;
    end
    return hr_ok && (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Four-digit BCD entry buffer; clear+shift together loads a lone digit into ls_min.
module key_shift_reg
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] din,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min
);

  logic [3:0] ms_hr_r, ls_hr_r, ms_min_r, ls_min_r;

  // Digit storage: clear, shift left, or hold.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ms_hr_r  <= 4'd0;
      ls_hr_r  <= 4'd0;
      ms_min_r <= 4'd0;
      ls_min_r <= shift_en && !reset ? din : 4'd0;
    end else if (shift_en) begin
      ms_hr_r  <= ls_hr_r;
      ls_hr_r  <= ms_min_r;
      ms_min_r <= ls_min_r;
      ls_min_r <= din;
    end else begin
      ms_hr_r  <= ms_hr_r;
      ls_hr_r  <= ls_hr_r;
      ms_min_r <= ms_min_r;
      ls_min_r <= ls_min_r;
    end
  end

  assign ms_hr  = ms_hr_r;
  assign ls_hr  = ls_hr_r;
  assign ms_min = ms_min_r;
  assign ls_min = ls_min_r;

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad HH:MM entry controller feeding the time counter and alarm register.
// Optional commit range check enabled by defining KEY_ENTRY_VALIDATE_EN.
module key_entry_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       entry_error
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_SEC - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};

  entry_state_t       state_r, state_nxt_s;
  logic [TIMER_W-1:0] timer_r, timer_nxt_s;
  logic               load_c_r, load_a_r, error_r;
  logic               load_c_nxt_s, load_a_nxt_s, error_nxt_s;
  logic               buf_clr_s, buf_shift_s;
  logic               key_digit_s, commit_s, time_ok_s, timeout_s;

  assign key_digit_s = key_valid && (key <= KEY_DIGIT_MAX);
  assign commit_s    = time_button || alarm_button;
  assign timeout_s   = one_second && (timer_r == TIMER_LAST);

`ifdef KEY_ENTRY_VALIDATE_EN
  assign time_ok_s = time_is_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                                   new_current_time_ms_min, new_current_time_ls_min);
`else
  assign time_ok_s = 1'b1;
`endif

  // State, idle timer and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      timer_r  <= TIMER_ZERO;
      load_c_r <= 1'b0;
      load_a_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      load_c_r <= load_c_nxt_s;
      load_a_r <= load_a_nxt_s;
      error_r  <= error_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (key_digit_s) begin
          state_nxt_s = ST_ENTRY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (commit_s) begin
          state_nxt_s = ST_IDLE;
        end else if (key_digit_s) begin
          state_nxt_s = ST_ENTRY;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ENTRY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Buffer control, timer update and strobe generation; time beats alarm on a tie.
  always_comb begin
    buf_clr_s    = 1'b0;
    buf_shift_s  = 1'b0;
    timer_nxt_s  = timer_r;
    load_c_nxt_s = 1'b0;
    load_a_nxt_s = 1'b0;
    error_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_digit_s) begin
          buf_clr_s   = 1'b1;
          buf_shift_s = 1'b1;
          timer_nxt_s = TIMER_ZERO;
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      ST_ENTRY: begin
        if (commit_s) begin
          if (time_ok_s) begin
            load_c_nxt_s = time_button;
            load_a_nxt_s = !time_button;
          end else begin
            error_nxt_s = 1'b1;
            buf_clr_s   = 1'b1;
          end
        end else if (key_digit_s) begin
          buf_shift_s = 1'b1;
          timer_nxt_s = TIMER_ZERO;
        end else if (timeout_s) begin
          buf_clr_s = 1'b1;
        end else if (one_second && (timer_r != TIMER_MAX)) begin
          timer_nxt_s = timer_r + TIMER_ONE;
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      default: begin
        buf_clr_s   = 1'b1;
        timer_nxt_s = TIMER_ZERO;
      end
    endcase
  end

  key_shift_reg u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr_s),
    .shift_en (buf_shift_s),
    .din      (key),
    .ms_hr    (new_current_time_ms_hr),
    .ls_hr    (new_current_time_ls_hr),
    .ms_min   (new_current_time_ms_min),
    .ls_min   (new_current_time_ls_min)
  );

  assign load_new_c    = load_c_r;
  assign load_new_a    = load_a_r;
  assign entry_error   = error_r;
  assign show_new_time = (state_r == ST_ENTRY);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed scenarios plus random traffic vs. an HHMM-number model.
module tb_key_entry_ctrl;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_new_time, entry_error;

  int tests = 0;
  int fails = 0;

  // Reference model: the entry is a decimal number of its last four digits.
  bit m_entry = 1'b0;
  int m_num   = 0;
  int m_idle  = 0;
  bit m_lc = 1'b0, m_la = 1'b0, m_err = 1'b0;

  key_entry_ctrl #(.TIMEOUT_SEC(TO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_second              (one_second),
    .key                     (key),
    .key_valid               (key_valid),
    .time_button             (time_button),
    .alarm_button            (alarm_button),
    .new_current_time_ms_hr  (ms_hr),
    .new_current_time_ls_hr  (ls_hr),
    .new_current_time_ms_min (ms_min),
    .new_current_time_ls_min (ls_min),
    .load_new_c              (load_new_c),
    .load_new_a              (load_new_a),
    .show_new_time           (show_new_time),
    .entry_error             (entry_error)
  );

  always #5 clk = ~clk;

  function automatic bit model_valid(int num);
`ifdef KEY_ENTRY_VALIDATE_EN
    return (num / 100 <= 23) && (num % 100 <= 59);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_update(bit r, bit kv, int k, bit tb_, bit ab, bit os);
    m_lc = 1'b0; m_la = 1'b0; m_err = 1'b0;
    if (r) begin
      m_entry = 1'b0; m_num = 0; m_idle = 0;
    end else if (!m_entry) begin
      if (kv && k < 10) begin
        m_num = k; m_idle = 0; m_entry = 1'b1;
      end
    end else if (tb_ || ab) begin
      if (model_valid(m_num)) begin
        if (tb_) m_lc = 1'b1; else m_la = 1'b1;
      end else begin
        m_err = 1'b1; m_num = 0;
      end
      m_entry = 1'b0;
    end else if (kv && k < 10) begin
      m_num = (m_num * 10 + k) % 10000; m_idle = 0;
    end else if (os) begin
      m_idle++;
      if (m_idle == TO) begin
        m_entry = 1'b0; m_num = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_digits;
    exp_digits = {4'(m_num / 1000), 4'((m_num / 100) % 10), 4'((m_num / 10) % 10), 4'(m_num % 10)};
    check("digits", {ms_hr, ls_hr, ms_min, ls_min}, exp_digits);
    check("show_new_time", {15'd0, show_new_time}, {15'd0, m_entry});
    check("load_new_c", {15'd0, load_new_c}, {15'd0, m_lc});
    check("load_new_a", {15'd0, load_new_a}, {15'd0, m_la});
    check("entry_error", {15'd0, entry_error}, {15'd0, m_err});
  endtask

  task automatic step(bit r, bit kv, int k, bit tb_, bit ab, bit os);
    reset = r; key_valid = kv; key = 4'(k);
    time_button = tb_; alarm_button = ab; one_second = os;
    @(posedge clk);
    model_update(r, kv, k, tb_, ab, os);
    #1;
    reset = 1'b0; key_valid = 1'b0; key = 4'd0;
    time_button = 1'b0; alarm_button = 1'b0; one_second = 1'b0;
    check_all();
  endtask

  task automatic press(int k);
    step(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // 12:34 to the time counter.
    press(1); press(2); press(3); press(4);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycle(); idle_cycle();

    // 09:59 to the alarm register.
    press(0); press(9); press(5); press(9);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle_cycle();

    // 24:00 is out of range when validation is built in.
    press(2); press(4); press(0); press(0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycle();

    // Buttons in IDLE do nothing.
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);

    // Timeout after three ticks.
    press(5); tick(); idle_cycle(); tick(); tick(); idle_cycle();

    // A key restarts the idle count.
    press(5); tick(); tick(); press(6); tick(); tick(); idle_cycle(); tick(); idle_cycle();

    // Ignored key codes neither shift nor restart the timer.
    press(7); tick(); press(13); tick(); press(15); tick(); idle_cycle();

    // Both buttons: time wins.
    press(1); press(1); press(3); press(0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle_cycle();

    // Overflow with an ignored key interleaved, then reset mid-entry.
    press(1); press(2); press(12); press(3); press(4); press(5);
    idle_cycle();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit r, kv, tb_, ab, os;
      int k;
      r   = ($urandom_range(0, 199) == 0);
      kv  = ($urandom_range(0, 99) < 35);
      k   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      tb_ = ($urandom_range(0, 99) < 5);
      ab  = ($urandom_range(0, 99) < 5);
      os  = ($urandom_range(0, 99) < 25);
      step(r, kv, k, tb_, ab, os);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
